// File: rtl/param_ram_sweep_pkg.sv
// Shared types and elaboration helpers for the param_ram_sweep storage block.
package param_ram_sweep_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic bit read_lat_legal(input int unsigned lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/param_ram_core.sv
// Storage array: byte-masked synchronous write port, registered read port.
module param_ram_core
  import param_ram_sweep_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [lane_count(DATA_W)-1:0] wr_mask,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately unreset; the clear sweep initialises it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/param_ram_sweep.sv
// Single-port RAM with byte enables, 1- or 2-cycle read latency and a
// hardware clear sweep that initialises every word after reset or on request.
module param_ram_sweep
  import param_ram_sweep_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       READ_LAT = 1,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [lane_count(DATA_W)-1:0] byte_en,
  input  logic                          write_en,
  input  logic                          read_en,
  output logic [DATA_W-1:0]             data_out,
  output logic                          read_valid,
  output logic                          busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LANES = lane_count(DATA_W);

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("param_ram_sweep: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("param_ram_sweep: DATA_W must be a multiple of 8");
  end

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  logic              rd_fire;
  logic              core_we;
  logic [LANES-1:0]  core_mask;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_q;
  logic              v1;

  assign busy    = (state == CLEAR);
  assign rd_fire = !busy && read_en;

  // The sweep owns the single port while busy; in IDLE a clear request
  // drops any write on the same edge but still lets a read through.
  always_comb begin
    core_we    = 1'b0;
    core_mask  = byte_en;
    core_addr  = address;
    core_wdata = data_in;
    if (busy) begin
      core_we    = 1'b1;
      core_mask  = '1;
      core_addr  = ptr;
      core_wdata = CLR_VAL;
    end else begin
      core_we = write_en && !clear;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  param_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (core_we),
    .wr_mask (core_mask),
    .addr    (core_addr),
    .wr_data (core_wdata),
    .rd_en   (rd_fire),
    .rd_data (core_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
    end else begin
      v1 <= rd_fire;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          d2 <= core_q;
        end
      end
    end

    assign read_valid = v2;
    assign data_out   = d2;
  end else begin : g_lat1
    assign read_valid = v1;
    assign data_out   = core_q;
  end

endmodule

// File: tb/tb_param_ram_sweep.sv
// Randomised and directed bench for param_ram_sweep: instance 0 uses defaults,
// instance 1 uses READ_LAT=2 and CLR_VAL=32'hDEADBEEF; both run against a reference model.
module tb_param_ram_sweep;

  logic        clk;
  logic        rst  [2];
  logic        clr  [2];
  logic        we   [2];
  logic        re   [2];
  logic [4:0]  addr [2];
  logic [31:0] din  [2];
  logic [3:0]  be   [2];
  logic [31:0] dout [2];
  logic        rv   [2];
  logic        bsy  [2];

  int unsigned n_cmp;
  int unsigned n_bad;

  // Reference model state
  logic [31:0] mmem  [2][32];
  bit          mbusy [2];
  int unsigned mptr  [2];
  bit          mv    [2];
  logic [31:0] md    [2];
  bit          pv    [2];
  logic [31:0] pd    [2];
  int unsigned lat_m [2];
  logic [31:0] clrv  [2];

  param_ram_sweep #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .READ_LAT (1),
    .CLR_VAL  (32'h0000_0000)
  ) dut0 (
    .clock      (clk),
    .reset      (rst[0]),
    .clear      (clr[0]),
    .address    (addr[0]),
    .data_in    (din[0]),
    .byte_en    (be[0]),
    .write_en   (we[0]),
    .read_en    (re[0]),
    .data_out   (dout[0]),
    .read_valid (rv[0]),
    .busy       (bsy[0])
  );

  param_ram_sweep #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .READ_LAT (2),
    .CLR_VAL  (32'hDEAD_BEEF)
  ) dut1 (
    .clock      (clk),
    .reset      (rst[1]),
    .clear      (clr[1]),
    .address    (addr[1]),
    .data_in    (din[1]),
    .byte_en    (be[1]),
    .write_en   (we[1]),
    .read_en    (re[1]),
    .data_out   (dout[1]),
    .read_valid (rv[1]),
    .busy       (bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    mbusy[k] = 1'b1;
    mptr[k]  = 0;
    mv[k]    = 1'b0;
    md[k]    = '0;
    pv[k]    = 1'b0;
    pd[k]    = '0;
  endtask

  // One rising edge of the behavioural model, using the inputs present before the edge.
  task automatic model_edge(input int k);
    bit          nv;
    logic [31:0] nd;
    nv = 1'b0;
    nd = '0;
    if (rst[k]) return;
    if (mbusy[k]) begin
      mmem[k][mptr[k]] = clrv[k];
      mptr[k]++;
      if (mptr[k] == 32) begin
        mbusy[k] = 1'b0;
        mptr[k]  = 0;
      end
    end else begin
      if (re[k]) begin
        nv = 1'b1;
        nd = mmem[k][addr[k]];
      end
      if (clr[k]) begin
        mbusy[k] = 1'b1;
        mptr[k]  = 0;
      end else if (we[k]) begin
        for (int b = 0; b < 4; b++)
          if (be[k][b]) mmem[k][addr[k]][8*b +: 8] = din[k][8*b +: 8];
      end
    end
    if (lat_m[k] == 1) begin
      mv[k] = nv;
      if (nv) md[k] = nd;
    end else begin
      mv[k] = pv[k];
      if (pv[k]) md[k] = pd[k];
      pv[k] = nv;
      pd[k] = nd;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(mbusy[k]));
      check($sformatf("rvalid%0d", k), 32'(rv[k]), 32'(mv[k]));
      check($sformatf("dout%0d", k), dout[k], md[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    compare_all();
  endtask

  task automatic drive(input int k, input bit w, input bit r, input bit c,
                       input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    we[k]   = w;
    re[k]   = r;
    clr[k]  = c;
    addr[k] = a;
    din[k]  = d;
    be[k]   = b;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
  endtask

  task automatic drive_random(input int k, input int unsigned clr_odds);
    logic [4:0] a;
    a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, clr_odds) == 0), a, $urandom, 4'($urandom));
  endtask

  task automatic assert_reset(input int k);
    rst[k] = 1'b1;
    model_reset(k);
    #1;
    check($sformatf("rst_rvalid%0d", k), 32'(rv[k]), 32'd0);
    check($sformatf("rst_dout%0d", k), dout[k], 32'd0);
    check($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    n_cmp = 0;
    n_bad = 0;
    lat_m[0] = 1;
    lat_m[1] = 2;
    clrv[0]  = 32'h0000_0000;
    clrv[1]  = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      idle(k);
      rst[k] = 1'b1;
      model_reset(k);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("por_rvalid%0d", k), 32'(rv[k]), 32'd0);
      check($sformatf("por_dout%0d", k), dout[k], 32'd0);
      check($sformatf("por_busy%0d", k), 32'(bsy[k]), 32'd1);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Sweep after reset, with requests thrown at both instances that must be ignored
    n = 0;
    while (bsy[0] && n < 100) begin
      n++;
      drive_random(0, 4);
      drive_random(1, 4);
      step();
    end
    check("t1_busy_cycles", 32'(n), 32'd32);
    idle(0);
    idle(1);

    drive(0, 1'b0, 1'b1, 1'b0, 5'b10111, 32'd0, 4'h0);
    step();
    check("t1_rvalid", 32'(rv[0]), 32'd1);
    check("t1_dout", dout[0], 32'h0000_0000);
    idle(0);
    step();
    check("t1_rvalid_fall", 32'(rv[0]), 32'd0);

    drive(0, 1'b1, 1'b0, 1'b0, 5'b10111, 32'hAAC3_B504, 4'hF);
    step();
    drive(0, 1'b0, 1'b1, 1'b0, 5'b10111, 32'd0, 4'h0);
    step();
    check("t2_rvalid", 32'(rv[0]), 32'd1);
    check("t2_dout", dout[0], 32'hAAC3_B504);

    drive(0, 1'b1, 1'b0, 1'b0, 5'b10111, 32'h1122_3344, 4'b0101);
    step();
    drive(0, 1'b0, 1'b1, 1'b0, 5'b10111, 32'd0, 4'h0);
    step();
    check("t3_dout", dout[0], 32'hAA22_B544);

    drive(0, 1'b1, 1'b0, 1'b0, 5'b01101, 32'hB304_5DF5, 4'hF);
    step();
    drive(0, 1'b1, 1'b1, 1'b0, 5'b01101, 32'h1EC6_5FC2, 4'hF);
    step();
    check("t4_rbw_old", dout[0], 32'hB304_5DF5);
    drive(0, 1'b0, 1'b1, 1'b0, 5'b01101, 32'd0, 4'h0);
    step();
    check("t4_rbw_new", dout[0], 32'h1EC6_5FC2);
    idle(0);
    step();

    drive(0, 1'b1, 1'b0, 1'b0, 5'b11111, 32'h8230_DAA3, 4'hF);
    step();
    drive(0, 1'b0, 1'b0, 1'b1, 5'b00000, 32'd0, 4'h0);
    step();
    n = 0;
    while (bsy[0] && n < 100) begin
      n++;
      drive(0, 1'b1, 1'b0, 1'b0, 5'b11111, 32'h5555_5555, 4'hF);
      step();
    end
    check("t5_busy_cycles", 32'(n), 32'd32);
    drive(0, 1'b0, 1'b1, 1'b0, 5'b11111, 32'd0, 4'h0);
    step();
    check("t5_dout", dout[0], 32'h0000_0000);
    idle(0);

    // Instance 1: reset while a read is in flight, then again mid-sweep
    drive(1, 1'b0, 1'b1, 1'b0, 5'b00011, 32'd0, 4'h0);
    step();
    idle(1);
    assert_reset(1);
    step();
    check("t6_flushed", 32'(rv[1]), 32'd0);
    rst[1] = 1'b0;
    n = 0;
    while (bsy[1] && n < 100) begin
      n++;
      step();
    end
    check("t6_first_sweep", 32'(n), 32'd32);
    drive(1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 4'h0);
    step();
    idle(1);
    repeat (10) step();
    assert_reset(1);
    step();
    step();
    rst[1] = 1'b0;
    n = 0;
    while (bsy[1] && n < 100) begin
      n++;
      step();
    end
    check("t6_busy_cycles", 32'(n), 32'd32);
    drive(1, 1'b0, 1'b1, 1'b0, 5'b00011, 32'd0, 4'h0);
    step();
    check("t6_rvalid_lat1", 32'(rv[1]), 32'd0);
    idle(1);
    step();
    check("t6_rvalid_lat2", 32'(rv[1]), 32'd1);
    check("t6_dout", dout[1], 32'hDEAD_BEEF);

    repeat (800) begin
      drive_random(0, 63);
      drive_random(1, 63);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_ram_sweep.md
Name: param_ram_sweep

Overview:
- Parametrised single-port synchronous RAM with per-byte write enables, a configurable read latency with a `read_valid` strobe, and a hardware clear engine.
- The clear engine sweeps every location to a fixed value after reset and on request. It reports progress on `busy`.
- This block is the next generation of the fixed 32x32 lab memory. It is the storage block that later register-file and buffer blocks instantiate.

Parameters:
- DATA_W, 32, data word width in bits. Must be a multiple of 8.
- ADDR_W, 5, address width. DEPTH = 2**ADDR_W is a localparam, so every address is in range.
- READ_LAT, 1, read latency in cycles. Legal values are 1 and 2; any other value fails at elaboration.
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear sweep.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  one-cycle request to start a clear sweep.
- address  in  ADDR_W  word address for read or write.
- data_in  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write strobe. Bit i qualifies data_in[8i+7:8i].
- write_en  in  1  write request.
- read_en  in  1  read request.
- data_out  out  DATA_W  read data. Registered; holds its last value between reads.
- read_valid  out  1  one-cycle pulse, high in the cycle data_out presents a new read result.
- busy  out  1  high while the clear sweep is in progress.

Behaviour:
- Reset, asynchronous:
  - data_out=0, read_valid=0, read pipeline flushed.
  - State goes to CLEAR with sweep pointer 0, so busy=1.
  - The memory array itself is not reset; the sweep initialises it.
- States: CLEAR, IDLE. busy = (state==CLEAR), decoded directly from the state register.
- CLEAR:
  - Each rising edge writes CLR_VAL to mem[ptr] (all bytes) and increments ptr.
  - The edge that writes DEPTH-1 sets state=IDLE and ptr=0.
  - busy is therefore high for exactly DEPTH cycles after reset release. With default parameters that is 32 cycles.
- IDLE to CLEAR: on an edge sampling clear=1. Addresses 0..DEPTH-1 are then written on the following DEPTH edges.
- While busy:
  - write_en, read_en and clear are ignored; no request is queued.
  - No new read_valid is launched.
- Write, in IDLE:
  - On an edge with write_en=1, each byte i with byte_en[i]=1 updates mem[address][8i+7:8i].
  - Bytes with byte_en[i]=0 are preserved.
  - byte_en=0 is a legal no-op.
- Read, in IDLE:
  - On an edge with read_en=1, the addressed word is captured.
  - READ_LAT=1: data_out and read_valid=1 appear after that edge, i.e. in the next cycle.
  - READ_LAT=2: one extra register stage; the result appears one cycle later.
  - read_valid falls the cycle after unless another read follows. Back-to-back reads give one result per cycle.
- Simultaneous read and write to the same address, same edge: read-before-write. The read returns the old word; the next read returns the merged word.
- clear and write_en on the same IDLE edge: clear wins and the write is dropped. A read on that edge is still serviced.
- Reads already in the pipeline when a sweep starts complete normally. read_valid is delivered with pre-clear data.
- Reset asserted mid-sweep, or mid-read:
  - The pipeline is flushed and read_valid=0 immediately.
  - The sweep restarts from address 0 after reset release.
- Width rules:
  - ptr is ADDR_W bits; wrap from DEPTH-1 coincides with the exit to IDLE.
  - No arithmetic on data words.

Decomposition:
- Shared package holds:
  - the state typedef {CLEAR, IDLE};
  - the legal-READ_LAT check constant;
  - the helper function for byte-lane count (DATA_W/8).
- One sub-module, param_ram_core: a pure storage array with a byte-masked synchronous write port and a registered read port.
- The top level holds the sweep FSM, the request gating, the clear/write arbitration and the optional second read stage.

Test Plan:
1. Release reset; count busy-high cycles = 32. Then read_en at address 5'b10111 -> read_valid one cycle later, data_out=32'h00000000.
2. Write 32'hAAC3B504 to 5'b10111 with byte_en=4'hF, then read 5'b10111 -> data_out=32'hAAC3B504 with read_valid one cycle after the read edge (READ_LAT=1).
3. After step 2, write 32'h11223344 to 5'b10111 with byte_en=4'b0101, then read -> data_out=32'hAA22B544.
4. Preload 5'b01101 = 32'hB3045DF5. Same edge: write 32'h1EC65FC2 with byte_en=4'hF and read_en to 5'b01101 -> data_out=32'hB3045DF5. The next read returns 32'h1EC65FC2.
5. Write 32'h8230DAA3 to 5'b11111. Pulse clear, and issue write_en to 5'b11111 while busy -> busy high 32 cycles, write ignored. A subsequent read of 5'b11111 returns 32'h00000000.
6. READ_LAT=2, CLR_VAL=32'hDEADBEEF instance:
   - Assert reset at sweep cycle 10 -> busy stays high for 32 full cycles after release.
   - A read of 5'b00011 then yields 32'hDEADBEEF with read_valid two cycles after the read edge.
